multi_counter_regs: RTL
=======================

Name: multi_counter_regs

Overview:
- Parametrised successor to the single event counter: NUM_CH independent counters, each with its own enable, direction, wrap/saturate mode, compare value and sticky status flags.
- All channels are controlled and observed through the existing s_addr / s_wr_data / s_wr_en / s_rd_en register-interface style.
- Single clock domain; the block sits behind the lab register bus and counts per-channel event pulses.

Parameters:
- NUM_CH, 4, number of counter channels (1..8).
- CNT_VAL_W, 8, counter width in bits (1..DATA_W).
- DATA_W, 16, register data width.
- ADDR_W, 4, register address width; NUM_CH*4 <= 2**ADDR_W is required (elaboration error otherwise).

Ports:
- clk  in  1  block clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- s_addr  in  ADDR_W  register address.
- s_wr_data  in  DATA_W  write data.
- s_wr_en  in  1  write strobe, single-cycle.
- s_rd_en  in  1  read strobe, single-cycle.
- s_rd_data  out  DATA_W  read data.
- s_rd_data_valid  out  1  read data qualifier.
- ev  in  NUM_CH  per-channel count event, 1 = step this cycle.
- irq  out  1  interrupt, see Optional Feature.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. All counters, CMP, CTRL and STATUS clear to 0; s_rd_data=0; s_rd_data_valid=0; irq=0.
- Address decode:
  - ch = s_addr[ADDR_W-1:2]; reg = s_addr[1:0].
  - ch >= NUM_CH is unmapped: writes ignored, reads return 0 with valid asserted.
- Registers per channel:
  - reg 0 CTRL: bit0 EN; bit1 DIR (0 up, 1 down); bit2 SAT (0 wrap, 1 saturate); bit3 CLR, write-only and self-clearing, reads 0; bit4 IRQ_EN (macro only).
  - reg 1 VALUE: read = current count; write loads s_wr_data[CNT_VAL_W-1:0].
  - reg 2 CMP: compare value, CNT_VAL_W bits.
  - reg 3 STATUS: bit0 MATCH, bit1 OVF; both sticky, write-1-to-clear.
  - Unused bits read 0; write data above CNT_VAL_W is truncated.
- Counting, evaluated per channel each cycle:
  - A step happens when EN=1 and ev[ch]=1; count ±1 per DIR.
  - Wrap mode: up from 2^CNT_VAL_W-1 gives 0; down from 0 gives max. Either wrap sets OVF.
  - Saturate mode: a step past max (up) or past 0 (down) holds the value and sets OVF.
  - MATCH sets in the cycle the next count value equals CMP as a result of a step. Load or clear never sets MATCH.
- Update priority per channel, highest first:
  1. CTRL write with CLR=1 forces count to 0; other CTRL bits are written in the same cycle.
  2. VALUE write loads the count.
  3. Event step.
  4. Hold.
  - A step dropped by higher priority is not counted and sets no flag.
- STATUS W1C in the same cycle as a flag set: the set wins, flag stays 1.
- Read timing:
  - s_rd_data and s_rd_data_valid are registered, 1-cycle latency.
  - Data is sampled from the pre-update state of the s_rd_en cycle.
  - valid is high exactly one cycle per s_rd_en.
  - s_rd_en and s_wr_en in the same cycle: both are performed; the read returns the old value.
  - s_rd_data holds its last value while valid=0.
- Asserting rst mid-operation clears everything immediately. Events arriving while rst is asserted are ignored.

Optional Feature:
- Macro: MULTI_COUNTER_IRQ_EN.
- Defined:
  - CTRL bit4 IRQ_EN is implemented (read/write).
  - irq is registered: irq = OR over ch of IRQ_EN & (MATCH | OVF), with 1-cycle delay after the flag sets.
  - irq deasserts the cycle after the last contributing flag clears.
- Undefined:
  - bit4 reads 0 and writes are ignored.
  - irq is tied to 0.

Test Plan:
- Reset, then read all 16 addresses -> every s_rd_data=0, valid exactly 1 cycle after each s_rd_en; unmapped channels (NUM_CH=3 build) read 0.
- ch1 CTRL=0x1, CMP=5, five ev[1] pulses -> VALUE=5, STATUS=0x1; other channels remain 0.
- ch0 VALUE=0xFE, wrap up, 3 events -> 0xFF, 0x00, 0x01, OVF=1. Repeat with SAT=1 -> holds 0xFF, OVF=1.
- ch2 DIR=1, VALUE=0, 1 event -> 0xFF with OVF; with SAT=1 -> stays 0x00 with OVF.
- Same cycle: VALUE write 0x10 plus ev -> 0x10. CTRL CLR plus ev -> 0. STATUS W1C plus MATCH event -> MATCH stays 1.
- MULTI_COUNTER_IRQ_EN build: IRQ_EN=1, trigger MATCH -> irq=1 the next cycle. W1C STATUS -> irq=0 the next cycle. Assert rst mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/multi_counter_regs.sv
// multi_counter_regs: NUM_CH independent up/down event counters behind a
// simple register bus. Each channel has its own control (enable, direction,
// wrap/saturate), a compare value and sticky MATCH/OVF status flags.
// Reads are registered with one cycle of latency.
// Optional feature macro: MULTI_COUNTER_IRQ_EN (per-channel IRQ_EN bit and a
// registered interrupt output). Without it, irq is tied low.
module multi_counter_regs #(
    parameter int NUM_CH    = 4,
    parameter int CNT_VAL_W = 8,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wr_data,
    input  logic              s_wr_en,
    input  logic              s_rd_en,
    output logic [DATA_W-1:0] s_rd_data,
    output logic              s_rd_data_valid,
    input  logic [NUM_CH-1:0] ev,
    output logic              irq
);

    // Every channel needs four register slots in the address space.
    if (NUM_CH * 4 > 2 ** ADDR_W) begin : g_cfg_err
        $error("multi_counter_regs: NUM_CH*4 exceeds 2**ADDR_W");
    end

    localparam logic [CNT_VAL_W-1:0] CNT_MAX = '1;

    // Address split: upper bits select the channel, low two bits the register.
    logic [ADDR_W-1:0] ch_sel;
    logic [1:0]        reg_sel;
    assign ch_sel  = s_addr >> 2;
    assign reg_sel = s_addr[1:0];

    // Per-channel read views and interrupt contributions.
    logic [NUM_CH-1:0][DATA_W-1:0] ch_rd;
    logic [NUM_CH-1:0]             irq_src;

    // Write data above the counter width is simply dropped.
    logic unused_wr_bits;
    assign unused_wr_bits = ^s_wr_data;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_VAL_W-1:0] cnt_q, cnt_d;
        logic [CNT_VAL_W-1:0] cmp_q, cmp_d;
        logic                 en_q, en_d;
        logic                 dir_q, dir_d;
        logic                 sat_q, sat_d;
        logic                 match_q, match_d;
        logic                 ovf_q, ovf_d;
`ifdef MULTI_COUNTER_IRQ_EN
        logic                 irq_en_q, irq_en_d;
`endif
        logic [CNT_VAL_W-1:0] step_val;
        logic                 step_ovf;
        logic                 wr_hit;
        logic                 step;
        logic [DATA_W-1:0]    rd_val;

        assign wr_hit = s_wr_en && (ch_sel == ADDR_W'(gi));
        assign step   = en_q && ev[gi];

        // Candidate count after one step, with wrap/saturate handling.
        always_comb begin
            step_val = cnt_q;
            step_ovf = 1'b0;
            if (!dir_q) begin
                if (cnt_q == CNT_MAX) begin
                    step_ovf = 1'b1;
                    step_val = sat_q ? cnt_q : '0;
                end else begin
                    step_val = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    step_ovf = 1'b1;
                    step_val = sat_q ? cnt_q : CNT_MAX;
                end else begin
                    step_val = cnt_q - 1'b1;
                end
            end
        end

        // Next-state: register writes, then count priority clear > load > step.
        always_comb begin
            cnt_d   = cnt_q;
            cmp_d   = cmp_q;
            en_d    = en_q;
            dir_d   = dir_q;
            sat_d   = sat_q;
            match_d = match_q;
            ovf_d   = ovf_q;
`ifdef MULTI_COUNTER_IRQ_EN
            irq_en_d = irq_en_q;
`endif
            if (wr_hit && reg_sel == 2'd0) begin
                en_d  = s_wr_data[0];
                dir_d = s_wr_data[1];
                sat_d = s_wr_data[2];
`ifdef MULTI_COUNTER_IRQ_EN
                irq_en_d = s_wr_data[4];
`endif
            end
            if (wr_hit && reg_sel == 2'd2) begin
                cmp_d = s_wr_data[CNT_VAL_W-1:0];
            end
            // W1C first so that a flag set in the same cycle overrides it.
            if (wr_hit && reg_sel == 2'd3) begin
                match_d = match_q & ~s_wr_data[0];
                ovf_d   = ovf_q & ~s_wr_data[1];
            end
            if (wr_hit && reg_sel == 2'd0 && s_wr_data[3]) begin
                cnt_d = '0;
            end else if (wr_hit && reg_sel == 2'd1) begin
                cnt_d = s_wr_data[CNT_VAL_W-1:0];
            end else if (step) begin
                cnt_d = step_val;
                if (step_ovf) begin
                    ovf_d = 1'b1;
                end
                if (step_val == cmp_q) begin
                    match_d = 1'b1;
                end
            end
        end

        // Channel state registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q   <= '0;
                cmp_q   <= '0;
                en_q    <= 1'b0;
                dir_q   <= 1'b0;
                sat_q   <= 1'b0;
                match_q <= 1'b0;
                ovf_q   <= 1'b0;
`ifdef MULTI_COUNTER_IRQ_EN
                irq_en_q <= 1'b0;
`endif
            end else begin
                cnt_q   <= cnt_d;
                cmp_q   <= cmp_d;
                en_q    <= en_d;
                dir_q   <= dir_d;
                sat_q   <= sat_d;
                match_q <= match_d;
                ovf_q   <= ovf_d;
`ifdef MULTI_COUNTER_IRQ_EN
                irq_en_q <= irq_en_d;
`endif
            end
        end

        // Read view of the selected register; CLR and unused bits read 0.
        always_comb begin
            rd_val = '0;
            case (reg_sel)
                2'd0: begin
                    rd_val[0] = en_q;
                    rd_val[1] = dir_q;
                    rd_val[2] = sat_q;
`ifdef MULTI_COUNTER_IRQ_EN
                    rd_val[4] = irq_en_q;
`endif
                end
                2'd1: rd_val[CNT_VAL_W-1:0] = cnt_q;
                2'd2: rd_val[CNT_VAL_W-1:0] = cmp_q;
                default: begin
                    rd_val[0] = match_q;
                    rd_val[1] = ovf_q;
                end
            endcase
        end

        assign ch_rd[gi] = rd_val;
`ifdef MULTI_COUNTER_IRQ_EN
        assign irq_src[gi] = irq_en_q & (match_q | ovf_q);
`else
        assign irq_src[gi] = 1'b0;
`endif
    end

    // Channel select for reads; unmapped channels return 0.
    logic [DATA_W-1:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == ADDR_W'(i)) begin
                rd_mux = ch_rd[i];
            end
        end
    end

    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Registered read port: data sampled from pre-update state, held when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= s_rd_en;
            if (s_rd_en) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign s_rd_data       = rd_data_q;
    assign s_rd_data_valid = rd_valid_q;

`ifdef MULTI_COUNTER_IRQ_EN
    logic irq_q;

    // Interrupt follows the enabled flags with one cycle of delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |irq_src;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_src;
    assign unused_irq_src = ^irq_src;
    assign irq = 1'b0;
`endif

endmodule
